// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded bundle for execute, and owns the
// load-use stall sequencer, wrong-path flush and the syscall drain-to-halt sequence.
module id_ex_stage #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int DRAIN_CYCLES     = 3
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_instr,
    input  logic [16:0] id_ctrl,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        stall_id,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [16:0] ex_ctrl,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_dst,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        EX_HOLD   = 2'd0,
        EX_BUBBLE = 2'd1,
        EX_LOAD   = 2'd2
    } ex_op_t;

    // The first bubble is inserted from RUN, so STALL only covers the remaining ones.
    localparam int          LU_RELOAD = (LOAD_USE_BUBBLES > 1) ? LOAD_USE_BUBBLES - 2 : 0;
    localparam logic [3:0]  CNT_LU    = 4'(LU_RELOAD);
    localparam logic [3:0]  CNT_DRAIN = 4'(DRAIN_CYCLES - 1);

    state_t      state, state_next;
    ex_op_t      ex_op;
    logic [3:0]  cnt, cnt_next;
    logic        halt_set;
    logic        hazard;
    logic        ex_take;

    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;
    logic [31:0] imm_ext;
    logic [4:0]  dst_sel;
    logic        unused_bits;

    assign id_rs    = id_instr[25:21];
    assign id_rt    = id_instr[20:16];
    assign id_rd    = id_instr[15:11];
    assign id_imm16 = id_instr[15:0];

    assign unused_bits = ^{id_instr[31:26], id_instr[5:0]};

    assign imm_ext = id_ctrl[13] ? {{16{id_imm16[15]}}, id_imm16} : {16'h0000, id_imm16};
    assign dst_sel = (id_ctrl[3:0] == 4'b1101) ? 5'd31 : (id_ctrl[4] ? id_rd : id_rt);

    // A load in EX whose destination is a source of the ID instruction; $0 never counts.
    assign hazard = id_valid & ex_valid & ex_ctrl[7] & ex_ctrl[10] & (ex_dst != 5'd0) &
                    ((id_ctrl[15] & (id_rs == ex_dst)) | (id_ctrl[16] & (id_rt == ex_dst)));

    assign ex_take = (ex_op == EX_LOAD) & id_valid;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ex_op      = EX_HOLD;
        stall_id   = 1'b0;
        halt_set   = 1'b0;
        if (mem_busy) begin
            stall_id = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        ex_op = EX_BUBBLE;
                    end else if (hazard) begin
                        ex_op    = EX_BUBBLE;
                        stall_id = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_next = STALL;
                            cnt_next   = CNT_LU;
                        end
                    end else if (id_valid & id_ctrl[11]) begin
                        ex_op      = EX_LOAD;
                        state_next = DRAIN;
                        cnt_next   = CNT_DRAIN;
                    end else begin
                        ex_op = EX_LOAD;
                    end
                end
                STALL: begin
                    ex_op    = EX_BUBBLE;
                    stall_id = 1'b1;
                    if (cnt == 4'd0) state_next = RUN;
                    else             cnt_next   = cnt - 4'd1;
                end
                DRAIN: begin
                    ex_op    = EX_BUBBLE;
                    stall_id = 1'b1;
                    if (cnt == 4'd0) begin
                        state_next = HALTED;
                        halt_set   = 1'b1;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                HALTED: begin
                    ex_op    = EX_BUBBLE;
                    stall_id = 1'b1;
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= RUN;
            cnt        <= 4'd0;
            halted     <= 1'b0;
            ex_valid   <= 1'b0;
            ex_pc      <= 32'h0;
            ex_ctrl    <= 17'h0;
            ex_rs_data <= 32'h0;
            ex_rt_data <= 32'h0;
            ex_imm     <= 32'h0;
            ex_shamt   <= 5'd0;
            ex_dst     <= 5'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            halted <= halted | halt_set;
            // Anything other than a real capture leaves an all-zero bubble behind.
            if (ex_op != EX_HOLD) begin
                ex_valid   <= ex_take;
                ex_pc      <= ex_take ? id_pc      : 32'h0;
                ex_ctrl    <= ex_take ? id_ctrl    : 17'h0;
                ex_rs_data <= ex_take ? id_rs_data : 32'h0;
                ex_rt_data <= ex_take ? id_rt_data : 32'h0;
                ex_imm     <= ex_take ? imm_ext    : 32'h0;
                ex_shamt   <= ex_take ? id_instr[10:6] : 5'd0;
                ex_dst     <= ex_take ? dst_sel    : 5'd0;
            end
        end
    end

endmodule
